// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider controller.
//   state_t : controller state encoding
//   MIN_DIV : smallest divide ratio that produces a valid output period
package freq_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Ratio configuration port of the divider controller.
//   cfg_valid : new divide ratio offered (master -> slave)
//   cfg_div   : offered ratio (master -> slave)
//   cfg_ready : controller can accept a ratio (slave -> master)
//   pending   : accepted ratio waiting for a period boundary (slave -> master)
//   cfg_err   : one-cycle pulse, illegal ratio accepted and discarded (slave -> master)
interface freq_div_ctrl_if #(
   parameter int CW = 8
);
   logic          cfg_valid;
   logic [CW-1:0] cfg_div;
   logic          cfg_ready;
   logic          pending;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_div,
      input  cfg_ready, pending, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_div,
      output cfg_ready, pending, cfg_err
   );
endinterface

// File: rtl/freq_div_ctrl_counter.sv
// Divide-by-N period counter with registered clk_out and tick.
//   clk, rst   : system clock, synchronous active-low reset
//   start      : begin a fresh period next cycle (cnt=0, clk_out=1, tick=1)
//   count      : counter is running (RUN or DRAIN)
//   stop       : final boundary of a drain; return to rest next cycle
//   load       : take load_div as the ratio in effect next cycle
//   load_div   : new ratio
//   boundary   : current cycle is the last of its period (cnt == cur_div-1)
//   clk_out    : divided clock
//   tick       : first cycle of every output period
//   cur_div    : ratio currently in effect
module freq_div_ctrl_counter #(
   parameter int CW          = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          count,
   input  logic          stop,
   input  logic          load,
   input  logic [CW-1:0] load_div,
   output logic          boundary,
   output logic          clk_out,
   output logic          tick,
   output logic [CW-1:0] cur_div
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] div_eff;
   logic [CW-1:0] hi;

   // A ratio loaded at a boundary must already shape the high phase of the
   // period that starts in the next cycle, so HI uses the incoming ratio.
   always_comb begin
      div_eff  = load ? load_div : cur_div;
      hi       = div_eff - (div_eff >> 1);
      boundary = (cnt == cur_div - CW'(1));
      cnt_nxt  = boundary ? '0 : cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         cur_div <= CW'(DEFAULT_DIV);
      end else begin
         if (load)
            cur_div <= load_div;
         if (start) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
         end else if (count && !stop) begin
            cnt     <= cnt_nxt;
            clk_out <= (cnt_nxt < hi);
            tick    <= boundary;
         end else begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/freq_div_ctrl.sv
// Runtime-programmable clock divider controller.
//   clk, rst : system clock, synchronous active-low reset
//   en       : run request (level)
//   cfg      : ratio configuration port (valid/ready, pending, cfg_err)
//   clk_out  : divided clock, registered
//   tick     : pulse on the first cycle of each output period
//   cur_div  : ratio currently in effect
//   busy     : controller is in RUN or DRAIN
//
// state | meaning
// IDLE  | stopped, clk_out low, ratio updates apply immediately
// RUN   | counting periods, en held high
// DRAIN | en dropped, finishing the current period before IDLE
module freq_div_ctrl
   import freq_div_pkg::*;
#(
   parameter int CW          = 8,
   parameter int DEFAULT_DIV = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   freq_div_ctrl_if.slave  cfg,
   output logic            clk_out,
   output logic            tick,
   output logic [CW-1:0]   cur_div,
   output logic            busy
);

   state_t        state;
   state_t        state_nxt;
   logic          pending;
   logic [CW-1:0] shadow;
   logic          cfg_err;
   logic          boundary;
   logic          start;
   logic          count;
   logic          stop;
   logic          accept;
   logic          legal;
   logic          apply_pend;
   logic          load;
   logic [CW-1:0] load_div;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         DRAIN:   if (en) state_nxt = RUN;
                  else if (boundary) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start = (state == IDLE) && en;
      count = (state == RUN) || (state == DRAIN);
      stop  = (state == DRAIN) && !en && boundary;
      busy  = count;
   end

   // A pending ratio is also flushed in IDLE: a handshake landing on the
   // final drain boundary would otherwise be stranded with no later boundary.
   always_comb begin
      accept     = cfg.cfg_valid && !pending;
      legal      = (cfg.cfg_div >= CW'(MIN_DIV));
      apply_pend = pending && ((count && boundary) || (state == IDLE));
      load       = apply_pend || (accept && legal && (state == IDLE));
      load_div   = apply_pend ? shadow : cfg.cfg_div;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= 1'b0;
         shadow  <= CW'(DEFAULT_DIV);
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && !legal;
         if (apply_pend) begin
            pending <= 1'b0;
         end else if (accept && legal && (state != IDLE)) begin
            pending <= 1'b1;
            shadow  <= cfg.cfg_div;
         end
      end
   end

   assign cfg.cfg_ready = !pending;
   assign cfg.pending   = pending;
   assign cfg.cfg_err   = cfg_err;

   freq_div_ctrl_counter #(
      .CW          (CW),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .count    (count),
      .stop     (stop),
      .load     (load),
      .load_div (load_div),
      .boundary (boundary),
      .clk_out  (clk_out),
      .tick     (tick),
      .cur_div  (cur_div)
   );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed self-checking bench for freq_div_ctrl.
module tb_freq_div_ctrl;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clk_out;
   logic       tick;
   logic [7:0] cur_div;
   logic       busy;
   int         total;
   int         bad;

   freq_div_ctrl_if #(.CW(8)) cfg_if ();

   freq_div_ctrl #(.CW(8), .DEFAULT_DIV(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cfg     (cfg_if),
      .clk_out (clk_out),
      .tick    (tick),
      .cur_div (cur_div),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      en    = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_div   = 8'd0;

      // reset state
      step();
      step();
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_cur_div", 32'(cur_div), 6);
      chk("rst_pending", 32'(cfg_if.pending), 0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(cfg_if.cfg_err), 0);

      // default div 6: 3 high / 3 low, tick every 6
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("div6_clk", 32'(clk_out), 32'((i % 6) < 3));
         chk("div6_tick", 32'(tick), 32'((i % 6) == 0));
         chk("div6_busy", 32'(busy), 1);
         chk("div6_cur", 32'(cur_div), 6);
      end

      // ratio 5 offered at cnt=0, applied at next boundary
      step();
      chk("chg_c0_clk", 32'(clk_out), 1);
      chk("chg_c0_tick", 32'(tick), 1);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd5;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("chg_pending", 32'(cfg_if.pending), 1);
      chk("chg_ready", 32'(cfg_if.cfg_ready), 0);
      chk("chg_c1_clk", 32'(clk_out), 1);
      for (int k = 2; k < 6; k++) begin
         step();
         chk("chg_old_clk", 32'(clk_out), 32'(k < 3));
         chk("chg_old_pending", 32'(cfg_if.pending), 1);
         chk("chg_old_cur", 32'(cur_div), 6);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         chk("div5_clk", 32'(clk_out), 32'((i % 5) < 3));
         chk("div5_tick", 32'(tick), 32'((i % 5) == 0));
         chk("div5_cur", 32'(cur_div), 5);
         chk("div5_pending", 32'(cfg_if.pending), 0);
         chk("div5_ready", 32'(cfg_if.cfg_ready), 1);
      end

      // illegal ratios 1 and 0
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd1;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("err1_pulse", 32'(cfg_if.cfg_err), 1);
      chk("err1_pending", 32'(cfg_if.pending), 0);
      chk("err1_cur", 32'(cur_div), 5);
      step();
      chk("err1_clear", 32'(cfg_if.cfg_err), 0);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd0;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("err0_pulse", 32'(cfg_if.cfg_err), 1);
      chk("err0_pending", 32'(cfg_if.pending), 0);
      chk("err0_cur", 32'(cur_div), 5);
      step();
      chk("err0_clear", 32'(cfg_if.cfg_err), 0);
      chk("err0_cur2", 32'(cur_div), 5);

      // now at cnt=3 of div 5; switch to div 4
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd4;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("d4_pending", 32'(cfg_if.pending), 1);
      chk("d4_c4_clk", 32'(clk_out), 0);
      step();
      chk("d4_cur", 32'(cur_div), 4);
      chk("d4_c0_tick", 32'(tick), 1);
      chk("d4_c0_clk", 32'(clk_out), 1);
      step();
      chk("d4_c1_clk", 32'(clk_out), 1);

      // drop en at cnt=1: drain completes 2 high / 2 low
      en = 1'b0;
      step();
      chk("drn_c2_clk", 32'(clk_out), 0);
      chk("drn_c2_busy", 32'(busy), 1);
      step();
      chk("drn_c3_clk", 32'(clk_out), 0);
      chk("drn_c3_busy", 32'(busy), 1);
      step();
      chk("drn_idle_clk", 32'(clk_out), 0);
      chk("drn_idle_busy", 32'(busy), 0);
      chk("drn_idle_tick", 32'(tick), 0);
      step();
      chk("idle_hold_clk", 32'(clk_out), 0);
      chk("idle_hold_tick", 32'(tick), 0);

      // restart, drop en, re-raise during drain: no gap
      en = 1'b1;
      step();
      chk("rr_c0_clk", 32'(clk_out), 1);
      chk("rr_c0_tick", 32'(tick), 1);
      step();
      chk("rr_c1_clk", 32'(clk_out), 1);
      en = 1'b0;
      step();
      chk("rr_c2_clk", 32'(clk_out), 0);
      chk("rr_c2_busy", 32'(busy), 1);
      en = 1'b1;
      step();
      chk("rr_c3_clk", 32'(clk_out), 0);
      chk("rr_c3_busy", 32'(busy), 1);
      step();
      chk("rr_next_c0_clk", 32'(clk_out), 1);
      chk("rr_next_c0_tick", 32'(tick), 1);
      step();
      chk("rr_next_c1_clk", 32'(clk_out), 1);
      chk("rr_next_c1_tick", 32'(tick), 0);
      en = 1'b0;
      step();
      step();
      step();
      chk("stop_busy", 32'(busy), 0);
      chk("stop_clk", 32'(clk_out), 0);

      // div 2 handshake together with en rising in IDLE
      en = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd2;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("d2_cur", 32'(cur_div), 2);
      chk("d2_pending", 32'(cfg_if.pending), 0);
      chk("d2_c0_clk", 32'(clk_out), 1);
      chk("d2_c0_tick", 32'(tick), 1);
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("d2_clk", 32'(clk_out), 32'((i % 2) == 0));
         chk("d2_tick", 32'(tick), 32'((i % 2) == 0));
      end

      // switch to div 8, then reset at cnt=3 with ratio 3 pending
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd8;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("d8_pending", 32'(cfg_if.pending), 1);
      step();
      chk("d8_cur", 32'(cur_div), 8);
      chk("d8_c0_tick", 32'(tick), 1);
      step();
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 8'd3;
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("d8_c2_clk", 32'(clk_out), 1);
      chk("d8_c2_pending", 32'(cfg_if.pending), 1);
      step();
      chk("d8_c3_clk", 32'(clk_out), 1);
      chk("d8_c3_pending", 32'(cfg_if.pending), 1);
      chk("d8_c3_cur", 32'(cur_div), 8);
      rst = 1'b0;
      step();
      chk("mr_clk", 32'(clk_out), 0);
      chk("mr_pending", 32'(cfg_if.pending), 0);
      chk("mr_cur", 32'(cur_div), 6);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_tick", 32'(tick), 0);
      chk("mr_ready", 32'(cfg_if.cfg_ready), 1);
      rst = 1'b1;
      en  = 1'b0;
      step();
      chk("post_clk", 32'(clk_out), 0);
      chk("post_busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Runtime-programmable clock divider controller that sequences a divide-by-N counter and drives clk_out.
- Generalises the fixed divide-by-6 divider: accepts new divide ratios over a valid/ready port and applies them only at output-period boundaries, so clk_out never glitches.
- Enable-driven start, and a graceful stop that finishes the current period before halting.
- Sits between the configuration/register logic and any downstream logic clocked or strobed by clk_out.

Parameters:
- CW, 8: width of the divide ratio and the internal counter.
- DEFAULT_DIV, 6: divide ratio loaded at reset. Must satisfy 2 <= DEFAULT_DIV <= 2^CW-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new divide ratio offered.
- cfg_div  input  CW  offered divide ratio; legal range 2..2^CW-1.
- cfg_ready  output  1  controller can accept a ratio.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the first cycle of every output period.
- cur_div  output  CW  ratio currently in effect.
- pending  output  1  an accepted ratio is waiting for a period boundary.
- cfg_err  output  1  one-cycle pulse: an illegal ratio was accepted and discarded.
- busy  output  1  state is RUN or DRAIN.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, cnt=0, clk_out=0, tick=0, cfg_err=0.
  - cur_div=DEFAULT_DIV, pending=0, busy=0, cfg_ready=1.
  - Reset mid-period aborts immediately, with no drain.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a clock edge.
  - cfg_ready = !pending (combinational from the register).
- Accepted ratio with cfg_div < 2:
  - Discarded; cfg_err=1 on the next cycle.
  - pending and cur_div are unchanged.
- Accepted legal ratio:
  - In IDLE: cur_div updates on the next cycle; pending stays 0.
  - In RUN/DRAIN: stored in a shadow register, pending=1 next cycle.
- Duty cycle: HI = cur_div - (cur_div>>1). clk_out=1 while cnt < HI, else 0.
  - Even ratios give 50% duty.
  - Odd ratios are high one cycle longer than low (e.g. div 5: 3 high, 2 low).
- State IDLE:
  - clk_out=0, cnt=0.
  - If en=1 at an edge, the next cycle is RUN with cnt=0, clk_out=1, tick=1.
- State RUN:
  - cnt increments each cycle.
  - When cnt==cur_div-1: next cnt=0, tick=1, clk_out=1.
  - If pending, cur_div takes the shadow value in that same boundary cycle and pending clears. The new HI applies from cnt=0.
  - If en=0 at an edge, go to DRAIN; counting continues uninterrupted.
- State DRAIN:
  - Counting continues unchanged.
  - en=1 → back to RUN with no gap or phase change.
  - At cnt==cur_div-1 with en=0: go to IDLE (cnt=0, clk_out=0, no tick).
  - A pending ratio is applied at that boundary, so pending=0 in IDLE.
- Simultaneous events:
  - A handshake in the same cycle as a boundary with pending=0 is not applied at that boundary. It becomes pending and waits for the next boundary.
  - Handshake in IDLE together with en rising: RUN starts with the new ratio.
- Latency:
  - en rising → clk_out high: 1 cycle.
  - Ratio change ≤ one current period plus 1 cycle.
- Width rules:
  - cnt is CW bits and never exceeds cur_div-1. No wrap beyond 2^CW-1.
  - HI is computed at CW bits, unsigned.

Decomposition:
- Shared package freq_div_pkg:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - MIN_DIV=2.
- Optional sub-module div_counter: cnt, HI compare, clk_out/tick generation, with a load input for cur_div.
- Controller keeps the FSM, shadow register and handshake.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=6 → clk_out repeats 3 high/3 low; tick every 6 cycles; busy=1; cur_div=6.
- While running at div 6, send cfg_div=5 mid-period → pending=1 and cfg_ready=0 until the next boundary; cur_div=5 at the boundary; then 3 high/2 low; no short pulse.
- Send cfg_div=1, and separately cfg_div=0 → each handshake completes, cfg_err pulses one cycle, cur_div is unchanged, pending=0.
- Drop en at cnt=1 of a div 4 period → clk_out completes 2 high/2 low, then IDLE, clk_out=0, busy=0. Re-raise en during DRAIN → continuous output with no phase gap.
- In IDLE, send cfg_div=2 in the same cycle en rises → RUN at div 2: clk_out toggles every cycle, tick every 2 cycles.
- Assert rst=0 for one cycle at cnt=3 of a div 8 period with a ratio pending → next cycle: IDLE, clk_out=0, pending=0, cur_div=6.
